bram_tile_cfg: RTL



---
 rtl/bram_cfg_pkg.sv | 68 ++++++
 rtl/bram_core.sv | 55 +++++
 rtl/bram_tile_cfg.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bram_cfg_pkg.sv
// ----------------------------------------------------------------------------
// bram_cfg_pkg
//   Shared types, constants and lane helpers for the configurable BRAM tile.
//   The physical word is four 8-bit byte lanes; the run-time aspect ratio
//   (x32 / x16 / x8) selects which lanes a logical access touches.
//
//   Contents:
//     MODE_X32/MODE_X16/MODE_X8  aspect-ratio encodings (3 is reserved -> x32)
//     clr_state_e                clear-sweep FSM states
//     lane_mask()                write byte-enable for a mode and lane select
//     lane_replicate()           spread narrow write data across all lanes
//     lane_extract()             pick and zero-extend a narrow read result
// ----------------------------------------------------------------------------
package bram_cfg_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned WORD_W    = NUM_LANES * LANE_W;

    localparam logic [1:0] MODE_X32 = 2'd0;
    localparam logic [1:0] MODE_X16 = 2'd1;
    localparam logic [1:0] MODE_X8  = 2'd2;

    typedef enum logic [0:0] {
        StClear,
        StReady
    } clr_state_e;

    // Byte-enable for one logical write. x16 only looks at sel[0].
    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] mode,
                                                       input logic [1:0] sel);
        logic [NUM_LANES-1:0] mask;
        case (mode)
            MODE_X16: mask = sel[0] ? 4'b1100 : 4'b0011;
            MODE_X8:  mask = 4'b0001 << sel;
            default:  mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Narrow write data is copied into every lane; the mask then picks one.
    function automatic logic [WORD_W-1:0] lane_replicate(input logic [WORD_W-1:0] data,
                                                         input logic [1:0]        mode);
        logic [WORD_W-1:0] rep;
        case (mode)
            MODE_X16: rep = {2{data[15:0]}};
            MODE_X8:  rep = {4{data[7:0]}};
            default:  rep = data;
        endcase
        return rep;
    endfunction

    // Select the addressed half/byte of a word and zero-extend it.
    function automatic logic [WORD_W-1:0] lane_extract(input logic [WORD_W-1:0] word,
                                                       input logic [1:0]        mode,
                                                       input logic [1:0]        sel);
        logic [WORD_W-1:0] shifted;
        logic [WORD_W-1:0] res;
        shifted = word >> {sel, 3'b000};
        case (mode)
            MODE_X16: res = sel[0] ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
            MODE_X8:  res = {24'h000000, shifted[7:0]};
            default:  res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bram_core.sv
// ----------------------------------------------------------------------------
// bram_core
//   DEPTH x DATA_WIDTH storage array with one byte-masked write port and one
//   synchronous read-first read port. Kept deliberately plain so it can be
//   replaced by an SRAM macro wrapper with the same port list.
//
//   Ports:
//     clk       clock, all activity on the rising edge
//     wr_en     write strobe (active-high)
//     wr_addr   word address of the write
//     wr_data   full-width write data
//     wr_mask   per-lane write enable, bit i covers lane i
//     rd_en     read strobe (active-high)
//     rd_addr   word address of the read
//     rd_data   registered read data, valid the cycle after rd_en
// ----------------------------------------------------------------------------
module bram_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned NUM_LANES  = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_LANES-1:0]  wr_mask,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned LaneW = DATA_WIDTH / NUM_LANES;

    logic [DATA_WIDTH-1:0] mem [Depth];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read and write share one block: the non-blocking read of mem picks up
    // the pre-write contents on a same-address collision (read-first).
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata_q <= mem[rd_addr];
        end
        if (wr_en) begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (wr_mask[i]) begin
                    mem[wr_addr][i*LaneW +: LaneW] <= wr_data[i*LaneW +: LaneW];
                end
            end
        end
    end

    assign rd_data = rdata_q;

endmodule

// File: rtl/bram_tile_cfg.sv
// ----------------------------------------------------------------------------
// bram_tile_cfg
//   Single-clock BRAM tile with run-time x32/x16/x8 aspect ratio per port,
//   read-valid strobe, optional output register and a post-reset sweep that
//   zeroes the array.
//
//   Ports (LA = ADDR_WIDTH + 2):
//     clk         clock
//     rst         synchronous active-high reset
//     rd_en       read request
//     rd_addr     logical read address [LA-1:0]
//     rd_data     read result, zero-extended in narrow modes, held otherwise
//     rd_valid    one-cycle strobe marking a read result on rd_data
//     wr_en       write request, polarity set by WR_EN_ACTIVE_LOW
//     wr_addr     logical write address [LA-1:0]
//     wr_data     write data, narrow modes use the low 16/8 bits
//     rd_mode     read aspect ratio (0=x32 1=x16 2=x8 3=x32)
//     wr_mode     write aspect ratio, same encoding
//     out_reg_en  add an output register stage (+1 cycle read latency)
//     busy        high while the clear sweep runs; requests are ignored
// ----------------------------------------------------------------------------
module bram_tile_cfg
    import bram_cfg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ADDR_WIDTH       = 9,
    parameter bit          WR_EN_ACTIVE_LOW = 1'b1,
    parameter bit          CLEAR_ON_RESET   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH+1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH+1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [1:0]            rd_mode,
    input  logic [1:0]            wr_mode,
    input  logic                  out_reg_en,
    output logic                  busy
);

    localparam int unsigned LA = ADDR_WIDTH + 2;

    // ------------------------------------------------------------------
    // Clear-sweep FSM
    // ------------------------------------------------------------------
    clr_state_e            state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!CLEAR_ON_RESET || (cnt_q == {ADDR_WIDTH{1'b1}})) begin
                        state_q <= StReady;
                    end
                end
                StReady: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

    assign busy = (state_q == StClear);

    // ------------------------------------------------------------------
    // Core port steering: the sweep owns the write port while busy.
    // ------------------------------------------------------------------
    logic                  wr_req;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_waddr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [NUM_LANES-1:0]  core_wmask;
    logic                  core_re;
    logic [DATA_WIDTH-1:0] core_rdata;

    assign wr_req = WR_EN_ACTIVE_LOW ? ~wr_en : wr_en;

    always_comb begin
        core_we    = 1'b0;
        core_waddr = wr_addr[ADDR_WIDTH-1:0];
        core_wdata = lane_replicate(wr_data, wr_mode);
        core_wmask = lane_mask(wr_mode, wr_addr[LA-1:ADDR_WIDTH]);
        if (busy) begin
            core_we    = CLEAR_ON_RESET;
            core_waddr = cnt_q;
            core_wdata = '0;
            core_wmask = '1;
        end else begin
            core_we    = wr_req;
        end
        // A write presented in the reset cycle is dropped.
        if (rst) begin
            core_we = 1'b0;
        end
    end

    assign core_re = rd_en && !busy && !rst;

    bram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_LANES  (NUM_LANES)
    ) u_core (
        .clk     (clk),
        .wr_en   (core_we),
        .wr_addr (core_waddr),
        .wr_data (core_wdata),
        .wr_mask (core_wmask),
        .rd_en   (core_re),
        .rd_addr (rd_addr[ADDR_WIDTH-1:0]),
        .rd_data (core_rdata)
    );

    // ------------------------------------------------------------------
    // Read pipeline: valid and lane select travel with the request so the
    // lane pick happens when the core data appears.
    // ------------------------------------------------------------------
    logic                  v1_q;
    logic                  v2_q;
    logic [1:0]            sel1_q;
    logic [1:0]            mode1_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] ext;

    assign ext = lane_extract(core_rdata, mode1_q, sel1_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            sel1_q  <= '0;
            mode1_q <= MODE_X32;
            data_q  <= '0;
        end else begin
            v1_q <= core_re;
            if (core_re) begin
                sel1_q  <= rd_addr[LA-1:ADDR_WIDTH];
                mode1_q <= rd_mode;
            end
            v2_q <= v1_q && out_reg_en;
            // data_q is both the output register and the hold register.
            if (v1_q) begin
                data_q <= ext;
            end
        end
    end

    always_comb begin
        rd_valid = out_reg_en ? v2_q : v1_q;
        rd_data  = data_q;
        if (!out_reg_en && v1_q) begin
            rd_data = ext;
        end
    end

endmodule
